// File: rtl/fulladder_checker_if.sv
// Port bundle between the checker and the 1-bit full adder under test.
// The master side drives the operand vector; the slave side returns sum and carry.
interface fulladder_checker_if;
  logic X1;
  logic X2;
  logic Cin;
  logic S;
  logic Cout;

  modport master (output X1, output X2, output Cin, input S, input Cout);
  modport slave  (input X1, input X2, input Cin, output S, output Cout);
endinterface

// File: rtl/fulladder_checker.sv
// Full-adder response checker: sweeps all eight input vectors and compares S/Cout with the truth table.
// Define FULLADDER_CHECK_HALT_EN to stop the sweep at the first mismatching vector.
module fulladder_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  fulladder_checker_if.master        fa,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [3:0]                 err_cnt,
  output logic                       fail_valid,
  output logic [2:0]                 fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic        fail_valid_q, fail_valid_d;
  logic [2:0]  fail_vec_q, fail_vec_d;

  logic        s_exp, cout_exp, mismatch, halt;

  always_comb begin
    s_exp    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    cout_exp = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch = (fa.S != s_exp) || (fa.Cout != cout_exp);
`ifdef FULLADDER_CHECK_HALT_EN
    halt = mismatch;
`else
    halt = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d        = 3'd0;
          cnt_d        = 8'd0;
          err_cnt_d    = 4'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_cnt_q < 4'd8) err_cnt_d = err_cnt_q + 4'd1;
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        // In halt mode the vector is left untouched so the failing inputs stay visible.
        if (halt || vec_q == 3'd7) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 4'd0);
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= 3'd0;
      cnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 4'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign fa.X1      = vec_q[2];
  assign fa.X2      = vec_q[1];
  assign fa.Cin     = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_fulladder_checker.sv
// Directed bench for fulladder_checker with a golden, a Cout-stuck-0 and an S-inverted adder model.
// Expectations follow FULLADDER_CHECK_HALT_EN when it is defined for the build.
module tb_fulladder_checker;

  localparam int PERIOD = 3;
`ifdef FULLADDER_CHECK_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;
  logic [2:0] vec_obs;
  logic [1:0] mode = 2'd0;
  int         passed = 0;
  int         total = 0;
  int         edges;

  fulladder_checker_if fa_bus ();

  // mode 0: golden adder, 1: Cout stuck at 0, 2: S inverted
  always_comb begin
    fa_bus.S    = fa_bus.X1 ^ fa_bus.X2 ^ fa_bus.Cin ^ (mode == 2'd2);
    fa_bus.Cout = (mode == 2'd1) ? 1'b0 :
                  ((fa_bus.X1 & fa_bus.X2) | (fa_bus.X1 & fa_bus.Cin) | (fa_bus.X2 & fa_bus.Cin));
  end

  assign vec_obs = {fa_bus.X1, fa_bus.X2, fa_bus.Cin};

  always #5 clk = ~clk;

  fulladder_checker #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fa         (fa_bus.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (done) break;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, 8'(busy), 8'd0);
    check_output({tag, "_done"}, 8'(done), 8'd0);
    check_output({tag, "_pass"}, 8'(pass), 8'd0);
    check_output({tag, "_err"}, 8'(err_cnt), 8'd0);
    check_output({tag, "_fvalid"}, 8'(fail_valid), 8'd0);
    check_output({tag, "_fvec"}, 8'(fail_vec), 8'd0);
    check_output({tag, "_vec"}, 8'(vec_obs), 8'd0);
  endtask

  initial begin
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Golden sweep, checked edge by edge for vector order, busy and done timing
    mode = 2'd0;
    pulse_start();
    check_output("g_e0_busy", 8'(busy), 8'd1);
    check_output("g_e0_vec", 8'(vec_obs), 8'd0);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("g_e%0d_vec", k), 8'(vec_obs), 8'((k < 24) ? k / PERIOD : 7));
      check_output($sformatf("g_e%0d_busy", k), 8'(busy), 8'(k < 24));
      check_output($sformatf("g_e%0d_done", k), 8'(done), 8'(k == 24));
    end
    check_output("g_pass", 8'(pass), 8'd1);
    check_output("g_err", 8'(err_cnt), 8'd0);
    check_output("g_fvalid", 8'(fail_valid), 8'd0);
    check_output("g_fvec", 8'(fail_vec), 8'd0);

    // Cout stuck at 0: vectors 3,5,6,7 fail
    mode = 2'd1;
    pulse_start();
    wait_done(edges);
    check_output("c0_edges", 8'(edges), HALT ? 8'd12 : 8'd24);
    check_output("c0_err", 8'(err_cnt), HALT ? 8'd1 : 8'd4);
    check_output("c0_fvec", 8'(fail_vec), 8'd3);
    check_output("c0_fvalid", 8'(fail_valid), 8'd1);
    check_output("c0_pass", 8'(pass), 8'd0);
    check_output("c0_busy", 8'(busy), 8'd0);
    check_output("c0_vec", 8'(vec_obs), HALT ? 8'd3 : 8'd7);

    // S inverted: every vector fails, count reaches 8 without wrapping
    mode = 2'd2;
    pulse_start();
    wait_done(edges);
    check_output("sinv_edges", 8'(edges), HALT ? 8'd3 : 8'd24);
    check_output("sinv_err", 8'(err_cnt), HALT ? 8'd1 : 8'd8);
    check_output("sinv_fvec", 8'(fail_vec), 8'd0);
    check_output("sinv_fvalid", 8'(fail_valid), 8'd1);
    check_output("sinv_pass", 8'(pass), 8'd0);

    // start re-pulsed on edges 5 and 10 must be ignored
    mode = 2'd0;
    pulse_start();
    edges = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      start = (k == 4 || k == 9);
      edges = k;
      if (done) break;
    end
    start = 1'b0;
    check_output("rep_edges", 8'(edges), 8'd24);
    check_output("rep_pass", 8'(pass), 8'd1);

    // start while done=1 clears done and reruns
    pulse_start();
    check_output("rerun_done", 8'(done), 8'd0);
    check_output("rerun_busy", 8'(busy), 8'd1);
    check_output("rerun_pass", 8'(pass), 8'd0);
    wait_done(edges);
    check_output("rerun_edges", 8'(edges), 8'd24);
    check_output("rerun_pass2", 8'(pass), 8'd1);
    check_output("rerun_err", 8'(err_cnt), 8'd0);

    // Asynchronous reset in the middle of a failing sweep
    mode = 2'd1;
    pulse_start();
    repeat (12) @(posedge clk);
    #1;
    check_output("mid_err", 8'(err_cnt), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd0;
    pulse_start();
    wait_done(edges);
    check_output("post_rst_edges", 8'(edges), 8'd24);
    check_output("post_rst_pass", 8'(pass), 8'd1);
    check_output("post_rst_err", 8'(err_cnt), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
